// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and the iteration-counter width helper.
package muldiv_pkg;

    // Bit 1 selects divide, bit 0 selects signed arithmetic.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Counter must index iterations 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One iteration per clock in CALC (shift-add multiply or restoring divide on
// a shared {acc_hi, acc_lo} register pair); FIX applies sign correction and
// commits the result to HI/LO with a one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand magnitudes; unsigned ops pass the raw operands through.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_abs = b_neg ? (~b + WIDTH'(1)) : b;

    logic             is_div;
    logic             negate;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   sub_y;
    logic             lo_zero;
    logic [WIDTH-1:0] prod_hi_neg;
    logic [WIDTH-1:0] rem_neg;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign is_div  = op_q[1];
    // Sign flags are latched as zero for unsigned ops, so this never fires there.
    assign negate  = sign_a_q ^ sign_b_q;
    // Multiply step: add multiplicand when the current multiplier bit is set.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divide step: remainder after shifting in the next dividend bit.
    assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign lo_zero = (acc_lo_q == '0);

    // One WIDTH+1 subtractor: divide trial in CALC, low-half negation in FIX.
    always_comb begin
        sub_a = rem_sh;
        sub_b = {1'b0, b_q};
        if (state_q == FIX) begin
            sub_a = '0;
            sub_b = {1'b0, acc_lo_q};
        end
        sub_y = sub_a - sub_b;
    end

    // Upper half of a negated 2*WIDTH product carries in only when the low half is zero.
    assign prod_hi_neg = ~acc_hi_q + {{(WIDTH-1){1'b0}}, lo_zero};
    assign rem_neg     = ~acc_hi_q + WIDTH'(1);

    // Final HI/LO selection applied in FIX.
    always_comb begin
        res_lo = negate ? sub_y[WIDTH-1:0] : acc_lo_q;
        res_hi = acc_hi_q;
        if (is_div) begin
            if (sign_a_q) res_hi = rem_neg;
        end else if (negate) begin
            res_hi = prod_hi_neg;
        end
    end

    // Controller, datapath and architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULTU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= CALC;
                        op_q     <= op_e'(op);
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        b_q      <= b_abs;
                        acc_hi_q <= '0;
                        acc_lo_q <= a_abs;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                    end else begin
                        if (wr_hi) hi_q <= wdata;
                        if (wr_lo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        // No borrow: keep the difference and set the quotient bit.
                        if (!sub_y[WIDTH]) begin
                            acc_hi_q <= sub_y[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_q <= rem_sh[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    dbz_q   <= is_div && (b_q == '0);
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, busy-window and
// reset scenarios, then randomized operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the MIPS arithmetic rules.
    task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        ed = o[1] && (bv == 0);
        case (o)
            2'b00: begin
                p  = {32'h0, av} * {32'h0, bv};
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                sa = $signed(av);
                sb = $signed(bv);
                p  = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b10: begin
                if (bv == 0) begin
                    el = '1;
                    eh = av;
                end else begin
                    el = av / bv;
                    eh = av % bv;
                end
            end
            default: begin
                ia = $signed(av);
                ib = $signed(bv);
                if (ib == 0) begin
                    el = (ia < 0) ? 32'd1 : 32'hFFFF_FFFF;
                    eh = av;
                end else if (av == 32'h8000_0000 && ib == -1) begin
                    el = 32'h8000_0000;
                    eh = 32'h0;
                end else begin
                    el = ia / ib;
                    eh = ia % ib;
                end
            end
        endcase
    endtask

    // Launch one operation (from #1 after an edge) and check the whole run.
    // pulse_at: cycle after acceptance at which a stray start + wr_hi is raised (-1 none).
    // wr_with_start: also raise wr_hi in the start cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed, input int pulse_at, input logic wr_with_start);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int           done_edge;
        logic         busy_ok;
        logic         hold_ok;
        prev_hi = hi;
        prev_lo = lo;
        start   = 1'b1;
        op      = o;
        a       = av;
        b       = bv;
        wr_hi   = wr_with_start;
        wdata   = 32'hDEAD_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check({tag, " busy@accept"}, W'(busy), W'(1));
        check({tag, " dbz@accept"}, W'(dbz), W'(0));
        done_edge = -1;
        busy_ok   = 1'b1;
        hold_ok   = (hi === prev_hi) && (lo === prev_lo);
        for (int k = 1; k <= W + 8 && done_edge < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == pulse_at + 1) begin
                start = 1'b0;
                wr_hi = 1'b0;
            end
            if (done) begin
                done_edge = k;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            end
            if (k == pulse_at) begin
                start = 1'b1;
                op    = 2'b11;
                a     = 32'h0000_0100;
                b     = 32'h0000_0003;
                wr_hi = 1'b1;
                wdata = 32'h0000_1234;
            end
        end
        start = 1'b0;
        wr_hi = 1'b0;
        check({tag, " latency"}, W'(done_edge), W'(W + 1));
        check({tag, " busy_window"}, W'(busy_ok), W'(1));
        check({tag, " hold_while_busy"}, W'(hold_ok), W'(1));
        check({tag, " busy@done"}, W'(busy), W'(0));
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " dbz"}, W'(dbz), W'(ed));
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b done@%0d [%s]",
                 o, av, bv, hi, lo, dbz, done_edge, tag);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
        int           sel;
        int           extra_done;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b10, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;

        // Reset state.
        #12;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset dbz", W'(dbz), W'(0));
        check("reset hi", hi, W'(0));
        check("reset lo", lo, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back-to-back (each start lands in the previous done cycle).
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, -1, 1'b0);
        end

        // Stray start and wr_hi while busy: ignored, single done.
        @(posedge clk);
        #1;
        run_op("busy_start", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 5, 1'b0);
        extra_done = 0;
        for (int k = 0; k < W + 8; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("no_second_done", W'(extra_done), W'(0));
        check("idle_busy", W'(busy), W'(0));
        check("hold_hi_idle", hi, W'(0));
        check("hold_lo_idle", lo, W'(15));

        // Start together with wr_hi: start wins.
        run_op("start_wins", 2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, -1, 1'b1);

        // Host writes in IDLE.
        @(posedge clk);
        #1;
        wr_hi = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi lo", lo, 32'd81);
        wr_lo = 1'b1;
        wdata = 32'hCAFE_0042;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo lo", lo, 32'hCAFE_0042);
        check("mtlo hi", hi, 32'h0000_1234);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("both hi", hi, 32'h5A5A_A5A5);
        check("both lo", lo, 32'h5A5A_A5A5);

        // Reset in the middle of a DIVU.
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", W'(busy), W'(0));
        check("midreset done", W'(done), W'(0));
        check("midreset hi", hi, W'(0));
        check("midreset lo", lo, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_reset", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1, 1'b0);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 20)) - 32'd10;
            model(ro, ra, rb, eh, el, ed);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
